// File: rtl/digit_serial_pkg.sv
// Shared digit-serial datapath definitions: digit/word geometry and the types
// used by the adder, deserializer and serializer.
package digit_serial_pkg;
    localparam int DIGIT_W  = 4;
    localparam int N_DIGITS = 8;
    localparam int W        = DIGIT_W * N_DIGITS;
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [W-1:0]       word_t;
    typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/digit_serial_deserializer.sv
// Reassembles LSD-first digits into parallel words behind a one-word output
// holding stage, flagging misplaced or missing s_first per word.
module digit_serial_deserializer
    import digit_serial_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   s_valid,
    output logic   s_ready,
    input  digit_t s_digit,
    input  logic   s_first,
    input  logic   s_carry,
    output logic   m_valid,
    input  logic   m_ready,
    output word_t  m_data,
    output logic   m_carry,
    output logic   m_error
);

    localparam cnt_t LAST = cnt_t'(N_DIGITS - 1);

    cnt_t  cnt;
    logic  err;
    logic  accept;
    logic  restart;
    logic  missing;
    logic  complete;
    word_t shifted;

    // Only the last digit can be held back, and only while an unread word sits in the output stage.
    assign s_ready  = (cnt != LAST) || !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign restart  = s_first && (cnt != '0);
    assign missing  = !s_first && (cnt == '0);
    assign complete = (cnt == LAST) && !restart;

    generate
        if (N_DIGITS > 1) begin : g_sr
            logic [W-DIGIT_W-1:0] sr;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sr <= '0;
                end else if (accept) begin
                    sr <= shifted[W-1:DIGIT_W];
                end
            end

            assign shifted = {s_digit, sr};
        end else begin : g_single
            assign shifted = s_digit;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            err     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_carry <= 1'b0;
            m_error <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    cnt     <= '0;
                    err     <= 1'b0;
                    m_data  <= shifted;
                    m_carry <= s_carry;
                    m_error <= err | restart | missing;
                end else begin
                    cnt <= restart ? cnt_t'(1) : cnt + cnt_t'(1);
                    err <= err | restart | missing;
                end
            end
            if (accept && complete) begin
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_deserializer.sv
// Bench for digit_serial_deserializer: directed vector table, corner-case
// sequences and randomized traffic against a word-level reference model.
package tb_top_pkg;
    string verdict = "";

    function automatic void test_done(input string v);
        verdict = v;
    endfunction
endpackage

module tb_digit_serial_deserializer;
    import digit_serial_pkg::*;

    logic   clk = 1'b0;
    logic   reset_n;
    logic   s_valid;
    logic   s_ready;
    digit_t s_digit;
    logic   s_first;
    logic   s_carry;
    logic   m_valid;
    logic   m_ready;
    word_t  m_data;
    logic   m_carry;
    logic   m_error;

    digit_serial_deserializer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_digit (s_digit),
        .s_first (s_first),
        .s_carry (s_carry),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_carry (m_carry),
        .m_error (m_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        err;
    } word_rec_t;

    typedef struct {
        logic [3:0] d;
        logic       f;
        logic       c;
    } dig_t;

    typedef struct {
        logic [31:0] word;
        logic        first_ok;
        logic        carry;
        logic [31:0] exp_data;
        logic        exp_carry;
        logic        exp_err;
    } vec_t;

    // Reference model: words in flight toward the sink, plus the word being gathered.
    word_rec_t   exp_q[$];
    word_rec_t   out_log[$];
    int          out_cyc[$];
    dig_t        dq[$];
    int          idx;
    logic [31:0] acc;
    logic        acc_err;

    int total;
    int bad;
    int cyc_n;
    int sr_low;
    int last_acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        idx     = 0;
        acc     = '0;
        acc_err = 1'b0;
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic f, input logic c,
                       input logic mr, output logic accepted);
        word_rec_t r;
        logic      exp_ready;
        s_valid = v;
        s_digit = d;
        s_first = f;
        s_carry = c;
        m_ready = mr;
        #1;
        exp_ready = !(idx == N_DIGITS - 1 && exp_q.size() != 0 && !mr);
        chk("s_ready", s_ready, exp_ready);
        chk("m_valid", m_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("m_data", m_data, exp_q[0].data);
            chk("m_carry", m_carry, exp_q[0].carry);
            chk("m_error", m_error, exp_q[0].err);
        end
        if (!s_ready) sr_low++;
        if (exp_q.size() != 0 && mr) begin
            r.data  = m_data;
            r.carry = m_carry;
            r.err   = m_error;
            out_log.push_back(r);
            out_cyc.push_back(cyc_n);
            void'(exp_q.pop_front());
        end
        accepted = v && s_ready;
        if (accepted) begin
            last_acc_cyc = cyc_n;
            if (f && idx != 0) begin
                acc_err = 1'b1;
                idx     = 0;
                acc     = '0;
            end else if (!f && idx == 0) begin
                acc_err = 1'b1;
            end
            acc[4*idx +: 4] = d;
            idx++;
            if (idx == N_DIGITS) begin
                r.data  = acc;
                r.carry = c;
                r.err   = acc_err;
                exp_q.push_back(r);
                idx     = 0;
                acc     = '0;
                acc_err = 1'b0;
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] word, input logic first_ok,
                             input logic carry, input logic mr);
        logic a;
        int   tries;
        for (int i = 0; i < N_DIGITS; i++) begin
            tries = 0;
            do begin
                cyc(1'b1, word[4*i +: 4], first_ok && i == 0, carry && i == N_DIGITS - 1, mr, a);
                tries++;
            end while (!a && tries < 64);
            if (!a) begin
                chk("send_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, a);
    endtask

    task automatic check_last(input string name, input int n0, input logic [31:0] data,
                              input logic carry, input logic err);
        chk({name, "_count"}, out_log.size(), n0 + 1);
        if (out_log.size() == n0 + 1) begin
            chk({name, "_data"}, out_log[n0].data, data);
            chk({name, "_carry"}, out_log[n0].carry, carry);
            chk({name, "_err"}, out_log[n0].err, err);
        end
    endtask

    task automatic push_digits(input logic [31:0] word, input logic carry);
        dig_t g;
        for (int i = 0; i < N_DIGITS; i++) begin
            g.d = word[4*i +: 4];
            g.f = (i == 0);
            g.c = carry && (i == N_DIGITS - 1);
            dq.push_back(g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[5];
        int   n0;
        int   low_at_hold;
        logic a;

        total = 0; bad = 0; cyc_n = 0; sr_low = 0; last_acc_cyc = 0;
        model_reset();
        tv[0] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0};
        tv[1] = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        tv[2] = '{32'h00000001, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
        tv[3] = '{32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
        tv[4] = '{32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0};

        reset_n = 1'b0;
        s_valid = 1'b0; s_digit = '0; s_first = 1'b0; s_carry = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_carry", m_carry, 0);
        chk("rst_m_error", m_error, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed words, including a missing s_first and the clean word after it.
        for (int t = 0; t < 5; t++) begin
            n0 = out_log.size();
            send_word(tv[t].word, tv[t].first_ok, tv[t].carry, 1'b1);
            idle(1);
            check_last("vec", n0, tv[t].exp_data, tv[t].exp_carry, tv[t].exp_err);
            if (t == 0 && out_cyc.size() != 0)
                chk("latency", out_cyc[out_cyc.size()-1], last_acc_cyc + 1);
        end

        // Back-to-back words with the sink always ready.
        n0 = out_log.size();
        sr_low = 0;
        send_word(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        send_word(32'h00000001, 1'b1, 1'b1, 1'b1);
        idle(1);
        chk("b2b_stall", sr_low, 0);
        chk("b2b_count", out_log.size(), n0 + 2);
        if (out_log.size() == n0 + 2) begin
            chk("b2b_w0", out_log[n0].data, 32'hFFFFFFFF);
            chk("b2b_w1", out_log[n0+1].data, 32'h00000001);
            chk("b2b_gap", out_cyc[n0+1] - out_cyc[n0], N_DIGITS);
        end

        // Backpressure: the sink stalls while two words stream in.
        n0 = out_log.size();
        sr_low = 0;
        push_digits(32'h13579BDF, 1'b1);
        push_digits(32'h2468ACE0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, dq[0].d, dq[0].f, dq[0].c, 1'b0, a);
            if (a) void'(dq.pop_front());
        end
        low_at_hold = sr_low;
        chk("bp_stall_cycles", low_at_hold, 5);
        chk("bp_none_out", out_log.size(), n0);
        for (int i = 0; i < 10 && dq.size() != 0; i++) begin
            cyc(1'b1, dq[0].d, dq[0].f, dq[0].c, 1'b1, a);
            if (a) void'(dq.pop_front());
        end
        chk("bp_drained", dq.size(), 0);
        idle(2);
        chk("bp_count", out_log.size(), n0 + 2);
        if (out_log.size() == n0 + 2) begin
            chk("bp_w1_data", out_log[n0].data, 32'h13579BDF);
            chk("bp_w1_carry", out_log[n0].carry, 1);
            chk("bp_w2_data", out_log[n0+1].data, 32'h2468ACE0);
            chk("bp_w2_carry", out_log[n0+1].carry, 0);
        end
        dq.delete();

        // Framing: s_first arrives on digit 3 of a partial word.
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'hA, i == 0, 1'b0, 1'b1, a);
        n0 = out_log.size();
        send_word(32'h0BADF00D, 1'b1, 1'b0, 1'b1);
        idle(1);
        check_last("frame", n0, 32'h0BADF00D, 1'b0, 1'b1);
        n0 = out_log.size();
        send_word(32'h600DF00D, 1'b1, 1'b1, 1'b1);
        idle(1);
        check_last("frame_clean", n0, 32'h600DF00D, 1'b1, 1'b0);

        // Reset in the middle of a word.
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'h5, i == 0, 1'b0, 1'b1, a);
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_carry", m_carry, 0);
        chk("mid_rst_m_error", m_error, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        n0 = out_log.size();
        send_word(32'hCAFEBABE, 1'b1, 1'b0, 1'b1);
        idle(1);
        check_last("after_rst", n0, 32'hCAFEBABE, 1'b0, 1'b0);

        // Randomized traffic with occasional framing faults and sink stalls.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0,
                4'($urandom_range(0, 15)),
                (idx == 0) ^ ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, a);
        end
        idle(3);
        chk("rand_drain", exp_q.size(), 0);

        tb_top_pkg::test_done(bad == 0 ? "PASS" : "FAIL");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
